// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and helpers for the four-digit multiplexed display scanner.
// Pure declarations: no timing and no flow control of its own.
package seg7_scan_ctrl_pkg;

`include "omdazz_defs.vh"

    typedef enum logic {
        ST_DEAD  = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lzb;
    } disp_t;

    // True when nibble 'dig' and every more-significant nibble of 'value' are zero.
    function automatic logic lead_zero(input logic [15:0] value, input logic [1:0] dig);
        logic z;
        z = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i >= int'(dig) && value[4*i +: 4] != 4'h0) begin
                z = 1'b0;
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/omdazz_defs.vh
// Board-level constants shared by the seven-segment scan logic: scan timing defaults
// and the active-low hex font (bit 7 is the decimal point, left off here).
`ifndef OMDAZZ_DEFS_VH
`define OMDAZZ_DEFS_VH

localparam int SCAN_DIV_DEF  = 50000;
localparam int BLANK_CYC_DEF = 500;

// Index 0 is the leftmost entry, so HEX_FONT[n] is the pattern for nibble n.
localparam logic [0:15][7:0] HEX_FONT = {
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
};

`endif

// File: rtl/seg7_hex_decoder.sv
// Nibble to active-low segment pattern (dp bit held high); purely combinational,
// zero latency, no flow control.
module seg7_hex_decoder
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        seg = HEX_FONT[nibble];
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-seg scanner; DIG/SEG registered one cycle behind the slot counter.
// Loads are double-buffered: IN_READY drops on accept and returns the cycle after FRAME_TICK.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF
) (
    input  logic        FPGA_CLK,
    input  logic        RESET_BUT,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [15:0] IN_VALUE,
    input  logic [3:0]  IN_DP,
    input  logic [3:0]  IN_BLANK,
    input  logic        IN_LZB,
    output logic [3:0]  DIG,
    output logic [7:0]  SEG,
    output logic        FRAME_TICK
);

    localparam int            CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    slot_q, slot_d;
    scan_state_t   state_q, state_d;
    disp_t         disp_q, disp_d;
    disp_t         pend_q, pend_d;
    logic          pend_full_q, pend_full_d;
    logic [3:0]    dig_q, dig_d;
    logic [7:0]    seg_q, seg_d;

    logic          frame_end;
    logic          accept;
    logic [1:0]    dig_idx;
    logic [3:0]    cur_nib;
    logic [7:0]    font_seg;
    logic          suppress;

    // Slot timing: counter, slot index and DEAD/DRIVE state all advance together.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        slot_d = slot_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            slot_d = slot_q + 2'd1;
        end
        state_d = (cnt_d < CNT_BLANK) ? ST_DEAD : ST_DRIVE;
    end

    assign frame_end = (cnt_q == CNT_LAST) && (slot_q == 2'd3);
    assign accept    = IN_VALID && !pend_full_q;

    always_comb begin
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (frame_end && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_d      = '{value: IN_VALUE, dp: IN_DP, blank: IN_BLANK, lzb: IN_LZB};
            pend_full_d = 1'b1;
        end
    end

    // Slot 0 is the leftmost digit, which is DIG bit 3 / nibble [15:12].
    assign dig_idx  = 2'd3 - slot_q;
    assign cur_nib  = disp_q.value[{dig_idx, 2'b00} +: 4];
    assign suppress = disp_q.lzb && (dig_idx != 2'd0) && lead_zero(disp_q.value, dig_idx);

    seg7_hex_decoder u_dec (
        .nibble (cur_nib),
        .seg    (font_seg)
    );

    always_comb begin
        dig_d = 4'hF;
        seg_d = 8'hFF;
        if (state_q == ST_DRIVE && !disp_q.blank[dig_idx]) begin
            if (suppress) begin
                // A suppressed zero keeps its decimal point visible.
                if (disp_q.dp[dig_idx]) begin
                    dig_d = ~(4'b0001 << dig_idx);
                    seg_d = 8'h7F;
                end
            end else begin
                dig_d = ~(4'b0001 << dig_idx);
                seg_d = font_seg & {~disp_q.dp[dig_idx], 7'h7F};
            end
        end
    end

    always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
        if (RESET_BUT) begin
            cnt_q       <= '0;
            slot_q      <= 2'd0;
            state_q     <= ST_DEAD;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            dig_q       <= 4'hF;
            seg_q       <= 8'hFF;
        end else begin
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            state_q     <= state_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            dig_q       <= dig_d;
            seg_q       <= seg_d;
        end
    end

    assign IN_READY   = !pend_full_q;
    assign DIG        = dig_q;
    assign SEG        = seg_q;
    assign FRAME_TICK = frame_end;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl with an 8-cycle slot, 2-cycle dead time and 32-cycle frame.
module tb_seg7_scan_ctrl;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FR = 4 * SD;

    localparam logic [7:0] FONT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_value = 16'h0;
    logic [3:0]  in_dp = 4'h0;
    logic [3:0]  in_blank = 4'h0;
    logic        in_lzb = 1'b0;
    logic [3:0]  dig;
    logic [7:0]  seg;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    int n = 0;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lzb;
    } mdisp_t;

    mdisp_t m_disp, m_pend;
    bit     m_full;

    typedef struct packed {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic            lzb;
        logic [0:3][3:0] dig;
        logic [0:3][7:0] seg;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .FPGA_CLK   (clk),
        .RESET_BUT  (rst),
        .IN_VALID   (in_valid),
        .IN_READY   (in_ready),
        .IN_VALUE   (in_value),
        .IN_DP      (in_dp),
        .IN_BLANK   (in_blank),
        .IN_LZB     (in_lzb),
        .DIG        (dig),
        .SEG        (seg),
        .FRAME_TICK (frame_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n);
        end
    endtask

    function automatic void model_reset();
        m_disp = '0;
        m_pend = '0;
        m_full = 1'b0;
        n      = 0;
    endfunction

    // What the display should show for a given slot/count under the display rules.
    function automatic void render(input mdisp_t d, input int slot, input int c,
                                   output logic [3:0] edig, output logic [7:0] eseg);
        int  k;
        int  nib;
        bit  sup;
        edig = 4'hF;
        eseg = 8'hFF;
        if (c < BC) return;
        k = 3 - slot;
        if (d.blank[k]) return;
        nib = int'((d.value >> (4 * k)) & 16'hF);
        sup = d.lzb && (k > 0) && ((d.value >> (4 * k)) == 16'h0);
        if (sup) begin
            if (d.dp[k]) begin
                edig = ~(4'b0001 << k);
                eseg = 8'h7F;
            end
            return;
        end
        edig = ~(4'b0001 << k);
        eseg = FONT[nib];
        if (d.dp[k]) eseg[7] = 1'b0;
    endfunction

    // One clock: advance the reference model over time slot u = n and compare all outputs.
    task automatic step();
        int         u;
        bit         acc;
        logic [3:0] edig;
        logic [7:0] eseg;
        @(posedge clk);
        u = n;
        render(m_disp, (u / SD) % 4, u % SD, edig, eseg);
        acc = in_valid && !m_full;
        if ((u % FR) == FR - 1 && m_full) begin
            m_disp = m_pend;
            m_full = 1'b0;
        end
        if (acc) begin
            m_pend = '{value: in_value, dp: in_dp, blank: in_blank, lzb: in_lzb};
            m_full = 1'b1;
        end
        n++;
        #1;
        check("dig", dig, edig);
        check("seg", seg, eseg);
        check("frame_tick", frame_tick, ((n % FR) == FR - 1) ? 1 : 0);
        check("in_ready", in_ready, m_full ? 0 : 1);
    endtask

    task automatic goto_phase(input int ph);
        int g = 0;
        do begin
            step();
            g++;
        end while (((n - 1) % FR) != ph && g < 4 * FR);
    endtask

    task automatic to_tick_edge();
        int g = 0;
        do begin
            step();
            g++;
        end while ((n % FR) != 0 && g < 4 * FR);
    endtask

    task automatic wait_ready();
        int g = 0;
        while (m_full && g < 3 * FR) begin
            step();
            g++;
        end
        if (m_full) check("ready_timeout", 1, 0);
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                        input logic lz);
        wait_ready();
        in_valid = 1'b1;
        in_value = v;
        in_dp    = dp;
        in_blank = bl;
        in_lzb   = lz;
        step();
        in_valid = 1'b0;
        in_value = 16'($urandom);
        in_dp    = 4'($urandom);
        in_blank = 4'($urandom);
        in_lzb   = 1'($urandom);
        check("ready_low_after_accept", in_ready, 0);
    endtask

    initial begin
        tbl[0] = '{16'h12AF, 4'h0, 4'h0, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE}, {8'hF9, 8'hA4, 8'h88, 8'h8E}};
        tbl[1] = '{16'h0005, 4'h4, 4'h0, 1'b1, {4'hF, 4'hB, 4'hF, 4'hE}, {8'hFF, 8'h7F, 8'hFF, 8'h92}};
        tbl[2] = '{16'h8888, 4'hF, 4'h0, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE}, {8'h00, 8'h00, 8'h00, 8'h00}};
        tbl[3] = '{16'h0000, 4'h0, 4'h0, 1'b1, {4'hF, 4'hF, 4'hF, 4'hE}, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        tbl[4] = '{16'h3C0D, 4'h1, 4'h4, 1'b0, {4'h7, 4'hF, 4'hD, 4'hE}, {8'hB0, 8'hFF, 8'hC0, 8'h21}};
        tbl[5] = '{16'h0B07, 4'h0, 4'h0, 1'b1, {4'hF, 4'hB, 4'hD, 4'hE}, {8'hFF, 8'h83, 8'hC0, 8'hF8}};
        tbl[6] = '{16'h0001, 4'h8, 4'h8, 1'b0, {4'hF, 4'hB, 4'hD, 4'hE}, {8'hFF, 8'hC0, 8'hC0, 8'hF9}};
        tbl[7] = '{16'hE964, 4'h0, 4'h0, 1'b1, {4'h7, 4'hB, 4'hD, 4'hE}, {8'h86, 8'h90, 8'h82, 8'h99}};
        tbl[8] = '{16'h0070, 4'h3, 4'h0, 1'b1, {4'hF, 4'hF, 4'hD, 4'hE}, {8'hFF, 8'hFF, 8'h78, 8'h40}};

        // Reset state.
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_dig", dig, 4'hF);
        check("rst_seg", seg, 8'hFF);
        check("rst_tick", frame_tick, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b0;

        // First slot after release: two dead cycles then digit 3 showing 0.
        for (int i = 0; i < SD; i++) begin
            step();
            check("boot_dig", dig, (i < BC) ? 4'hF : 4'h7);
            check("boot_seg", seg, (i < BC) ? 8'hFF : 8'hC0);
        end

        // Table of display patterns, each checked mid-slot in the frame after it lands.
        for (int e = 0; e < 9; e++) begin
            load(tbl[e].value, tbl[e].dp, tbl[e].blank, tbl[e].lzb);
            to_tick_edge();
            for (int s = 0; s < 4; s++) begin
                goto_phase(SD * s + 5);
                check("tbl_dig", dig, tbl[e].dig[s]);
                check("tbl_seg", seg, tbl[e].seg[s]);
            end
        end

        // Second value held while not ready: taken only after the frame boundary.
        wait_ready();
        in_valid = 1'b1;
        in_value = 16'h1111;
        in_dp    = 4'h0;
        in_blank = 4'h0;
        in_lzb   = 1'b0;
        step();
        in_value = 16'h2222;
        check("hold_ready_low", in_ready, 0);
        to_tick_edge();
        check("ready_rise_after_tick", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("second_accepted", in_ready, 0);
        goto_phase(5);
        check("frame_a_seg", seg, 8'hF9);
        to_tick_edge();
        goto_phase(5);
        check("frame_b_seg", seg, 8'hA4);

        // Accept on the FRAME_TICK cycle: shown one frame later.
        wait_ready();
        begin
            int g = 0;
            while ((n % FR) != FR - 1 && g < 2 * FR) begin
                step();
                g++;
            end
        end
        check("tick_before_accept", frame_tick, 1);
        in_valid = 1'b1;
        in_value = 16'h3333;
        step();
        in_valid = 1'b0;
        goto_phase(5);
        check("tick_accept_old_frame", seg, 8'hA4);
        to_tick_edge();
        goto_phase(5);
        check("tick_accept_next_frame", seg, 8'hB0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 7) == 0);
            in_value = 16'($urandom) >> (4 * $urandom_range(0, 3));
            in_dp    = 4'($urandom);
            in_blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            in_lzb   = 1'($urandom);
            step();
        end
        in_valid = 1'b0;

        // Reset during slot 2 with a load pending.
        load(16'h4444, 4'h0, 4'h0, 1'b0);
        goto_phase(2 * SD + 3);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_dig", dig, 4'hF);
        check("async_rst_seg", seg, 8'hFF);
        check("async_rst_ready", in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (BC + 1) step();
        check("post_rst_dig", dig, 4'h7);
        check("post_rst_seg", seg, 8'hC0);
        to_tick_edge();
        goto_phase(3 * SD + 5);
        check("pending_lost_dig", dig, 4'hE);
        check("pending_lost_seg", seg, 8'hC0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles per digit slot (1 ms at 50 MHz).
REQ-002 SHALL have parameter BLANK_CYC, default 500: dead-time cycles at the start of each slot; legal range 1 to SCAN_DIV-1.
REQ-003 SHALL have port FPGA_CLK  in  1: sole clock, rising edge.
REQ-004 SHALL have port RESET_BUT  in  1: reset, asynchronous, active-high.
REQ-005 SHALL have ports IN_VALID in 1 and IN_READY out 1: load handshake.
REQ-006 SHALL have port IN_VALUE  in  16: four hex nibbles; [15:12] leftmost.
REQ-007 SHALL have port IN_DP  in  4: decimal point per digit; bit 3 leftmost.
REQ-008 SHALL have port IN_BLANK  in  4: forced blank per digit; bit 3 leftmost.
REQ-009 SHALL have port IN_LZB  in  1: leading-zero blanking enable.
REQ-010 SHALL have port DIG  out  4: active-low digit enables; DIG[3] leftmost (board DIG_1).
REQ-011 SHALL have port SEG  out  8: active-low segments; [0..6]=a..g, [7]=dp.
REQ-012 SHALL have port FRAME_TICK  out  1: one-cycle pulse on the last cycle of slot 3.

Function
REQ-013 SHALL scan slots 0..3 driving DIG[3], DIG[2], DIG[1], DIG[0] in turn, from nibbles [15:12] down to [3:0]; slot 3 wraps to slot 0.
REQ-014 SHALL run a slot counter 0..SCAN_DIV-1; FSM state DEAD for counts 0..BLANK_CYC-1 and DRIVE for counts BLANK_CYC..SCAN_DIV-1.
REQ-015 SHALL hold DIG=4'hF and SEG=8'hFF in DEAD (anti-ghosting).
REQ-016 SHALL, in DRIVE, pull only the slot's DIG bit low and drive SEG from the display register; DIG/SEG registered, one cycle behind the counter.
REQ-017 SHALL use the hex font 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E (hex, dp bit 1), clearing SEG[7] when the digit's dp is set.
REQ-018 SHALL keep DIG high and SEG=FF for a digit whose IN_BLANK bit was latched set, dp included.
REQ-019 SHALL, with IN_LZB latched set, suppress the numeral of digits 3..1 that are zero with all more-significant nibbles zero; digit 0 is never suppressed. If dp is set on a suppressed digit, DIG SHALL be driven low with SEG=7F; otherwise DIG stays high.
REQ-020 SHALL accept a load when IN_VALID and IN_READY are both high, capturing VALUE/DP/BLANK/LZB into a pending register; IN_READY SHALL go low on the next cycle.
REQ-021 SHALL copy pending to the display register on the FRAME_TICK cycle only if pending was full before that cycle; IN_READY SHALL rise on the following cycle. Maximum load latency is one frame, with no mid-frame tearing.
REQ-022 SHALL, when an accept coincides with FRAME_TICK while pending is empty, store the value in pending only; it transfers at the next FRAME_TICK.
REQ-023 SHALL leave IN_VALID with IN_READY low without effect, and require no IN_VALUE stability outside the accept cycle.

Reset
REQ-024 SHALL, on RESET_BUT assertion and asynchronously, set DIG=F, SEG=FF, FRAME_TICK=0, IN_READY=1, counter=0, slot=0, state=DEAD, pending empty, and display register to value 0000 with dp/blank/lzb all 0.
REQ-025 SHALL, on reset mid-frame, discard any pending load; the first DRIVE after release shows slot 0 with 0.

Structure
REQ-026 SHALL place the font table and the SCAN_DIV/BLANK_CYC defaults in the shared include file omdazz_defs.vh.
REQ-027 SHALL implement the nibble-to-segment decode as combinational sub-module seg7_hex_decoder.

Verification (SCAN_DIV=8, BLANK_CYC=2, 32-cycle frame)
REQ-028 Release reset -> DIG=F and SEG=FF for 2 cycles, then DIG=0111 and SEG=C0 for 6 cycles; IN_READY=1.
REQ-029 Load 12AF -> IN_READY low until the frame ends; the next frame shows F9/A4/88/8E on DIG 0111/1011/1101/1110.
REQ-030 Load 0005 with LZB=1 and DP=0100 -> slot 0 DIG=F; slot 1 DIG=1011 and SEG=7F; slot 2 DIG=F; slot 3 DIG=1110 and SEG=92.
REQ-031 Hold IN_VALID with a second value while IN_READY is low -> not accepted until IN_READY rises after FRAME_TICK; display changes only at frame boundaries.
REQ-032 Accept on the FRAME_TICK cycle with pending empty -> the value appears one frame later, not the same frame.
REQ-033 Assert RESET_BUT during slot 2 with a pending load -> DIG=F and SEG=FF immediately; after release 0 is shown and the pending value is lost.
